sram_bitline_sense_ctrl: RTL and testbench
==========================================

Name: sram_bitline_sense_ctrl

Overview:
- Read-side controller for the mixed-signal SRAM column.
- Sequences bitline precharge and wordline assertion, then samples the real-valued bitline voltage every clock and resolves the stored bit by threshold crossing.
- Reports the resolved bit and the discharge latency in cycles.
- It is the observing end of the gate-drive/discharge path: the wordline drives the access nmosfet gate, and this block watches the resulting drain (bitline) voltage.

Parameters:
- PRECH_CYC, 4, cycles precharge_en is held high (legal range 1..2**CNT_W-1).
- TIMEOUT_CYC, 16, max sense cycles before declaring no discharge (legal range 1..2**CNT_W-1).
- CNT_W, 5, width of the cycle counter and lat_cnt.
- VREF, 0.75 (real, V), discharge detect threshold.
- VPRE_MIN, 1.4 (real, V), minimum acceptable precharged bitline.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  read request, sampled in IDLE only.
- vbl  input  real  bitline voltage (V), sampled on posedge clk.
- busy  output  1  high in every state except IDLE.
- precharge_en  output  1  bitline precharge enable.
- wl_en  output  1  wordline enable (drives the access device gate).
- data  output  1  resolved bit, held until the next data_valid.
- data_valid  output  1  one-cycle pulse when data/lat_cnt are updated.
- lat_cnt  output  CNT_W  sense cycles to crossing; TIMEOUT_CYC on timeout.
- prech_err  output  1  one-cycle pulse when precharge is insufficient.

Behaviour:
- Reset: when rst=1 at posedge, the state goes to IDLE and all outputs go to 0 (including data and lat_cnt). The internal counter goes to 0. This applies mid-operation; wl_en and precharge_en must drop on the same edge.
- States: IDLE, PRECH, SENSE, DONE. All outputs are registered.
- IDLE:
  - start=1 -> PRECH; precharge_en=1; cnt=0.
  - start is ignored in every other state; there is no queuing.
- PRECH:
  - cnt increments each cycle.
  - When cnt==PRECH_CYC-1, precharge_en->0 and vbl is checked on that edge.
  - vbl<VPRE_MIN: prech_err pulses; go to IDLE; no data_valid.
  - Otherwise: go to SENSE; wl_en->1; cnt=0.
  - precharge_en and wl_en are never high in the same cycle.
- SENSE:
  - Each posedge: if vbl<VREF, then data=0, lat_cnt=cnt+1, data_valid=1, wl_en->0, go to DONE.
  - Else, if cnt+1==TIMEOUT_CYC, then data=1, lat_cnt=TIMEOUT_CYC, data_valid=1, wl_en->0, go to DONE.
  - Else cnt increments.
  - Crossing and timeout on the same edge: crossing wins (data=0).
  - Comparison is strict; vbl==VREF is not a crossing.
- DONE: one cycle, wl_en=0, busy=1, then IDLE. A start during DONE is ignored.
- Latency:
  - start to wl_en rise: PRECH_CYC+1 cycles.
  - Minimum read, start to data_valid: PRECH_CYC+2 cycles.
  - Back-to-back reads: the next start is accepted at the earliest 1 cycle after DONE.
- Counter: cnt never exceeds max(PRECH_CYC, TIMEOUT_CYC)-1 and never wraps.
- vbl of NaN/X is treated as not below the threshold.

Test Plan:
- Reset mid-SENSE: start, then rst=1 while wl_en=1 -> next cycle wl_en=0, busy=0, data_valid=0, lat_cnt=0, state IDLE. A subsequent start completes normally.
- Stored 0: vbl=1.5 during precharge, then ramps down 0.1 V/cycle once wl_en rises -> crossing when vbl=0.7 on the 8th sense edge. Expect data=0, lat_cnt=8, single data_valid pulse, wl_en falls the same edge.
- Stored 1: vbl held at 1.5 throughout -> after 16 sense cycles data=1, lat_cnt=16, data_valid pulse. start to data_valid = 4+1+16 = 21 cycles.
- Weak precharge: vbl=1.2 at the end of PRECH -> prech_err pulses once, wl_en never rises, no data_valid, busy=0 the next cycle.
- Boundary/collision:
  - vbl=0.75 exactly for all sense cycles -> timeout, data=1.
  - vbl drops below VREF exactly on the 16th sense edge -> data=0, lat_cnt=16.
- Start while busy: start pulsed in PRECH, SENSE and DONE -> ignored, exactly one data_valid. A start 1 cycle after DONE begins a new read with precharge_en=1.

Source files
------------

// File: rtl/sram_bitline_sense_ctrl.sv
// Read-side sequencer for one SRAM column: precharges the bitline, raises the wordline,
// then resolves the stored bit from when (or whether) the bitline falls below VREF.
module sram_bitline_sense_ctrl #(
    parameter int  PRECH_CYC   = 4,
    parameter int  TIMEOUT_CYC = 16,
    parameter int  CNT_W       = 5,
    parameter real VREF        = 0.75,
    parameter real VPRE_MIN    = 1.4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  real              vbl,
    output logic             busy,
    output logic             precharge_en,
    output logic             wl_en,
    output logic             data,
    output logic             data_valid,
    output logic [CNT_W-1:0] lat_cnt,
    output logic             prech_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRECH = 2'd1,
        SENSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRECH_LAST   = CNT_W'(PRECH_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             prech_q, prech_d;
    logic             wl_q, wl_d;
    logic             data_q, data_d;
    logic             dv_q, dv_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             perr_q, perr_d;
    logic             below_vref_s;
    logic             below_vpre_s;

    // A NaN bitline compares false here, so it is never treated as a discharge.
    assign below_vref_s = (vbl < VREF);
    assign below_vpre_s = (vbl < VPRE_MIN);

    // Next-state and next-output logic; every output is a registered copy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prech_d = 1'b0;
        wl_d    = 1'b0;
        data_d  = data_q;
        dv_d    = 1'b0;
        lat_d   = lat_q;
        perr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRECH;
                    cnt_d   = CNT_ZERO;
                    prech_d = 1'b1;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            PRECH: begin
                if (cnt_q == PRECH_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (below_vpre_s) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SENSE;
                        wl_d    = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    prech_d = 1'b1;
                end
            end
            SENSE: begin
                // A crossing on the timeout edge still reads as a stored 0.
                if (below_vref_s) begin
                    data_d  = 1'b0;
                    lat_d   = cnt_q + CNT_ONE;
                    dv_d    = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    data_d  = 1'b1;
                    lat_d   = TIMEOUT_VAL;
                    dv_d    = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    wl_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            prech_q <= 1'b0;
            wl_q    <= 1'b0;
            data_q  <= 1'b0;
            dv_q    <= 1'b0;
            lat_q   <= CNT_ZERO;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            prech_q <= prech_d;
            wl_q    <= wl_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            lat_q   <= lat_d;
            perr_q  <= perr_d;
        end
    end

    assign busy         = busy_q;
    assign precharge_en = prech_q;
    assign wl_en        = wl_q;
    assign data         = data_q;
    assign data_valid   = dv_q;
    assign lat_cnt      = lat_q;
    assign prech_err    = perr_q;

endmodule

// File: tb/tb_sram_bitline_sense_ctrl.sv
// Directed bench for sram_bitline_sense_ctrl: each task drives one read scenario
// with a known bitline profile and checks hand-computed results.
module tb_sram_bitline_sense_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    real        vbl;
    logic       busy;
    logic       precharge_en;
    logic       wl_en;
    logic       data;
    logic       data_valid;
    logic [4:0] lat_cnt;
    logic       prech_err;

    int tests_run;
    int tests_failed;

    // Results gathered by run_read for the calling test to compare.
    int   r_dv_cnt;
    int   r_cyc_dv;
    logic r_data;
    int   r_lat;
    logic r_wl_at_dv;
    int   r_wl_rise;
    int   r_perr_cnt;
    logic r_busy_at_perr;
    int   r_prech_cnt;
    int   r_overlap;
    logic r_busy_end;

    sram_bitline_sense_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vbl          (vbl),
        .busy         (busy),
        .precharge_en (precharge_en),
        .wl_en        (wl_en),
        .data         (data),
        .data_valid   (data_valid),
        .lat_cnt      (lat_cnt),
        .prech_err    (prech_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bitline seen before edge n after the start edge; sense edge k = n - 4.
    function automatic real vbl_for(input int mode, input int n);
        int k;
        k = n - 4;
        if (k < 1) return (mode == 4) ? 1.2 : 1.5;
        case (mode)
            1:       return 1.5 - 0.1 * real'(k);
            2:       return 0.75;
            3:       return (k >= 16) ? 0.5 : 1.5;
            4:       return 1.2;
            default: return 1.5;
        endcase
    endfunction

    task automatic run_read(input int mode, input logic [63:0] start_at, input int n_edges);
        r_dv_cnt = 0; r_cyc_dv = -1; r_data = 1'bx; r_lat = -1; r_wl_at_dv = 1'bx;
        r_wl_rise = -1; r_perr_cnt = 0; r_busy_at_perr = 1'bx; r_prech_cnt = 0;
        r_overlap = 0; r_busy_end = 1'bx;
        vbl   = vbl_for(mode, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= n_edges; n++) begin
            vbl   = vbl_for(mode, n);
            start = start_at[n];
            tick();
            if (data_valid) begin
                r_dv_cnt++;
                r_cyc_dv   = n + 1;
                r_data     = data;
                r_lat      = int'(lat_cnt);
                r_wl_at_dv = wl_en;
            end
            if (wl_en && r_wl_rise < 0) r_wl_rise = n + 1;
            if (prech_err) begin
                r_perr_cnt++;
                r_busy_at_perr = busy;
            end
            if (precharge_en) r_prech_cnt++;
            if (precharge_en && wl_en) r_overlap++;
            r_busy_end = busy;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vbl = 1.5;
        tick();
        tick();
        tests_run++;
        if ({busy, precharge_en, wl_en, data, data_valid, lat_cnt, prech_err} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {busy, precharge_en, wl_en, data, data_valid, lat_cnt, prech_err});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stored0();
        run_read(1, 64'd0, 16);
        tests_run++;
        if (r_dv_cnt !== 1) begin tests_failed++; $display("FAIL s0_dv_count: got %0d required 1", r_dv_cnt); end
        tests_run++;
        if (r_data !== 1'b0 || r_lat !== 8) begin
            tests_failed++; $display("FAIL s0_result: data=%b lat=%0d required data=0 lat=8", r_data, r_lat);
        end
        tests_run++;
        if (r_cyc_dv !== 13) begin tests_failed++; $display("FAIL s0_latency: got %0d required 13", r_cyc_dv); end
        tests_run++;
        if (r_wl_at_dv !== 1'b0) begin tests_failed++; $display("FAIL s0_wl_fall: got %b required 0", r_wl_at_dv); end
        tests_run++;
        if (r_wl_rise !== 5) begin tests_failed++; $display("FAIL s0_wl_rise: got %0d required 5", r_wl_rise); end
        tests_run++;
        if (r_overlap !== 0) begin tests_failed++; $display("FAIL s0_overlap: got %0d required 0", r_overlap); end
        tests_run++;
        if (r_busy_end !== 1'b0) begin tests_failed++; $display("FAIL s0_busy_end: got %b required 0", r_busy_end); end
    endtask

    task automatic test_stored1();
        run_read(0, 64'd0, 24);
        tests_run++;
        if (r_dv_cnt !== 1 || r_data !== 1'b1 || r_lat !== 16) begin
            tests_failed++;
            $display("FAIL s1_result: dv=%0d data=%b lat=%0d required dv=1 data=1 lat=16", r_dv_cnt, r_data, r_lat);
        end
        tests_run++;
        if (r_cyc_dv !== 21) begin tests_failed++; $display("FAIL s1_latency: got %0d required 21", r_cyc_dv); end
    endtask

    task automatic test_weak_prech();
        run_read(4, 64'd0, 12);
        tests_run++;
        if (r_perr_cnt !== 1) begin tests_failed++; $display("FAIL weak_perr: got %0d required 1", r_perr_cnt); end
        tests_run++;
        if (r_dv_cnt !== 0 || r_wl_rise !== -1) begin
            tests_failed++; $display("FAIL weak_no_read: dv=%0d wl_rise=%0d required dv=0 wl_rise=-1", r_dv_cnt, r_wl_rise);
        end
        tests_run++;
        if (r_busy_at_perr !== 1'b0) begin tests_failed++; $display("FAIL weak_busy: got %b required 0", r_busy_at_perr); end
    endtask

    task automatic test_boundary();
        run_read(2, 64'd0, 24);
        tests_run++;
        if (r_data !== 1'b1 || r_lat !== 16 || r_dv_cnt !== 1) begin
            tests_failed++; $display("FAIL vref_equal: data=%b lat=%0d dv=%0d required data=1 lat=16 dv=1", r_data, r_lat, r_dv_cnt);
        end
        run_read(3, 64'd0, 24);
        tests_run++;
        if (r_data !== 1'b0 || r_lat !== 16 || r_cyc_dv !== 21) begin
            tests_failed++; $display("FAIL collision: data=%b lat=%0d cyc=%0d required data=0 lat=16 cyc=21", r_data, r_lat, r_cyc_dv);
        end
    endtask

    task automatic test_start_busy();
        logic [63:0] sa;
        sa = 64'd0;
        sa[2] = 1'b1; sa[10] = 1'b1; sa[21] = 1'b1;
        run_read(0, sa, 30);
        tests_run++;
        if (r_dv_cnt !== 1 || r_prech_cnt !== 3) begin
            tests_failed++; $display("FAIL start_busy: dv=%0d prech=%0d required dv=1 prech=3", r_dv_cnt, r_prech_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] sa;
        sa = 64'd0;
        sa[22] = 1'b1;
        run_read(0, sa, 45);
        tests_run++;
        if (r_dv_cnt !== 2 || r_prech_cnt !== 7 || r_cyc_dv !== 43) begin
            tests_failed++;
            $display("FAIL back_to_back: dv=%0d prech=%0d cyc=%0d required dv=2 prech=7 cyc=43", r_dv_cnt, r_prech_cnt, r_cyc_dv);
        end
    endtask

    task automatic test_reset_mid_sense();
        vbl = 1.5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 6; n++) tick();
        tests_run++;
        if (wl_en !== 1'b1) begin tests_failed++; $display("FAIL rms_pre_wl: got %b required 1", wl_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({busy, precharge_en, wl_en, data_valid, lat_cnt, prech_err} !== 10'd0) begin
            tests_failed++;
            $display("FAIL rms_cleared: got %b required all zero", {busy, precharge_en, wl_en, data_valid, lat_cnt, prech_err});
        end
        run_read(1, 64'd0, 16);
        tests_run++;
        if (r_dv_cnt !== 1 || r_lat !== 8 || r_data !== 1'b0) begin
            tests_failed++; $display("FAIL rms_after: dv=%0d lat=%0d data=%b required dv=1 lat=8 data=0", r_dv_cnt, r_lat, r_data);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b0;
        vbl   = 1.5;
        test_reset();
        test_stored0();
        test_stored1();
        test_weak_prech();
        test_boundary();
        test_start_busy();
        test_back_to_back();
        test_reset_mid_sense();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
